// File: rtl/wb_pc_cc_unit.sv
// -----------------------------------------------------------------------------
// wb_pc_cc_unit
//
// Commit (write-back / PC / condition-code) stage of the sequential Y-86 core.
// On each effective commit strobe it writes up to two registers (dstE <- valE,
// dstM <- valM, where valM wins on a collision), loads the condition codes for
// OPq, and selects the next PC. A RUN/HALT/ERR status machine freezes all
// architectural state once the program stops. The state is cleared only by
// reset.
//
// Parameters:
//   RESET_PC    PC value after reset
//   STACK_INIT  reset value of %rsp (register 4); all other registers reset to 0
//
// Ports:
//   clk, reset_n           clock, synchronous active-low reset
//   commit                 one instruction's results are valid this cycle
//   icode, ifun            instruction code / function of the committing instr
//   rA, rB                 register IDs (4'hF = none)
//   valE, valM, valC, valP ALU result, memory data, constant, next-seq PC
//   cnd                    branch/cmov condition
//   cc_out                 new flags {OF,SF,ZF} from execute
//   mem_error              address fault reported for this instruction
//   srcA, srcB             decode read addresses
//   valA, valB             combinational read data (0 for address 4'hF)
//   cc_in                  registered flags {OF,SF,ZF}
//   pc                     registered PC
//   stat                   1=AOK 2=HLT 3=ADR 4=INS
//   retired                count of committed instructions (wraps)
//
// Build option:
//   WB_FORWARD_EN  when defined, valA/valB bypass the pending write of the
//                  current effective commit (dstM is checked before dstE).
// -----------------------------------------------------------------------------
module wb_pc_cc_unit #(
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter logic [63:0] STACK_INIT = 64'h200
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        commit,
  input  logic [3:0]  icode,
  input  logic [3:0]  ifun,
  input  logic [3:0]  rA,
  input  logic [3:0]  rB,
  input  logic [63:0] valE,
  input  logic [63:0] valM,
  input  logic [63:0] valC,
  input  logic [63:0] valP,
  input  logic        cnd,
  input  logic [2:0]  cc_out,
  input  logic        mem_error,
  input  logic [3:0]  srcA,
  input  logic [3:0]  srcB,
  output logic [63:0] valA,
  output logic [63:0] valB,
  output logic [2:0]  cc_in,
  output logic [63:0] pc,
  output logic [2:0]  stat,
  output logic [63:0] retired
);

  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RSP   = 4'h4;

  typedef enum logic [1:0] {S_RUN, S_HALT, S_ERR} state_t;

  state_t      state_q, state_d;
  logic [2:0]  stat_q, stat_d;
  logic [63:0] pc_q, pc_d;
  logic [2:0]  cc_q, cc_d;
  logic [63:0] ret_q, ret_d;
  logic [63:0] rf_q [0:14];

  logic [3:0]  dst_e, dst_m;
  logic        we_e, we_m;

  // ifun does not influence commit behaviour (cnd already encodes it).
  logic unused_ifun;
  assign unused_ifun = ^ifun;

  // Destination decode
  always_comb begin
    dst_e = RNONE;
    dst_m = RNONE;
    case (icode)
      4'h3, 4'h6:              dst_e = rB;
      4'h2:                    dst_e = cnd ? rB : RNONE;
      4'h8, 4'h9, 4'hA, 4'hB:  dst_e = RSP;
      default:                 dst_e = RNONE;
    endcase
    if (icode == 4'h5 || icode == 4'hB) dst_m = rA;
  end

  // Status machine and next architectural state
  always_comb begin
    state_d = state_q;
    stat_d  = stat_q;
    pc_d    = pc_q;
    cc_d    = cc_q;
    ret_d   = ret_q;
    we_e    = 1'b0;
    we_m    = 1'b0;
    if (commit && state_q == S_RUN) begin
      if (mem_error) begin
        state_d = S_ERR;
        stat_d  = 3'd3;
      end else if (icode > 4'hB) begin
        state_d = S_ERR;
        stat_d  = 3'd4;
      end else if (icode == 4'h0) begin
        state_d = S_HALT;
        stat_d  = 3'd2;
        ret_d   = ret_q + 64'd1;
      end else begin
        we_e  = (dst_e != RNONE);
        we_m  = (dst_m != RNONE);
        ret_d = ret_q + 64'd1;
        if (icode == 4'h6) cc_d = cc_out;
        case (icode)
          4'h8:    pc_d = valC;
          4'h7:    pc_d = cnd ? valC : valP;
          4'h9:    pc_d = valM;
          default: pc_d = valP;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_RUN;
      stat_q  <= 3'd1;
      pc_q    <= RESET_PC;
      cc_q    <= 3'b001;
      ret_q   <= 64'd0;
    end else begin
      state_q <= state_d;
      stat_q  <= stat_d;
      pc_q    <= pc_d;
      cc_q    <= cc_d;
      ret_q   <= ret_d;
    end
  end

  // Register file; the valM port has priority when both target one register.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 15; i++) begin
      if (!reset_n) begin
        rf_q[i] <= (4'(i) == RSP) ? STACK_INIT : 64'd0;
      end else if (we_m && dst_m == 4'(i)) begin
        rf_q[i] <= valM;
      end else if (we_e && dst_e == 4'(i)) begin
        rf_q[i] <= valE;
      end
    end
  end

  // Read ports
  always_comb begin
    valA = (srcA == RNONE) ? 64'd0 : rf_q[srcA];
    valB = (srcB == RNONE) ? 64'd0 : rf_q[srcB];
`ifdef WB_FORWARD_EN
    // we_* already imply a real (non-4'hF) destination.
    if (we_m && srcA == dst_m)      valA = valM;
    else if (we_e && srcA == dst_e) valA = valE;
    if (we_m && srcB == dst_m)      valB = valM;
    else if (we_e && srcB == dst_e) valB = valE;
`endif
  end

  assign cc_in   = cc_q;
  assign pc      = pc_q;
  assign stat    = stat_q;
  assign retired = ret_q;

endmodule

// File: tb/tb_wb_pc_cc_unit.sv
module tb_wb_pc_cc_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        commit;
  logic [3:0]  icode, ifun, rA, rB, srcA, srcB;
  logic [63:0] valE, valM, valC, valP;
  logic        cnd, mem_error;
  logic [2:0]  cc_out;
  logic [63:0] valA, valB, pc, retired;
  logic [2:0]  cc_in, stat;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_pc_cc_unit #(.RESET_PC(64'h0), .STACK_INIT(64'h200)) dut (
    .clk(clk), .reset_n(reset_n), .commit(commit),
    .icode(icode), .ifun(ifun), .rA(rA), .rB(rB),
    .valE(valE), .valM(valM), .valC(valC), .valP(valP),
    .cnd(cnd), .cc_out(cc_out), .mem_error(mem_error),
    .srcA(srcA), .srcB(srcB), .valA(valA), .valB(valB),
    .cc_in(cc_in), .pc(pc), .stat(stat), .retired(retired)
  );

  typedef struct {
    logic [3:0]  icode, rA, rB;
    logic [63:0] valE, valM, valC, valP;
    logic        cnd;
    logic [2:0]  cc_out;
    logic [3:0]  chk_a, chk_b;
    logic [63:0] exp_pc;
    logic [2:0]  exp_cc;
    logic [63:0] exp_ret, exp_a, exp_b;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    commit = 0; icode = 4'h1; ifun = 0; rA = 4'hF; rB = 4'hF;
    valE = 0; valM = 0; valC = 0; valP = 0; cnd = 0; cc_out = 0;
    mem_error = 0; srcA = 4'hF; srcB = 4'hF;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 0;
    @(posedge clk);
    #1 reset_n = 1;
  endtask

  // One committed instruction; outputs are sampled 1 time unit after the edge.
  task automatic do_commit(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                           input logic [63:0] ve, input logic [63:0] vm,
                           input logic [63:0] vc, input logic [63:0] vp,
                           input logic cn, input logic [2:0] cco, input logic me);
    @(negedge clk);
    commit = 1; icode = ic; rA = ra; rB = rb; valE = ve; valM = vm;
    valC = vc; valP = vp; cnd = cn; cc_out = cco; mem_error = me;
    @(posedge clk);
    #1 commit = 0; mem_error = 0;
  endtask

  initial begin
    reset_n = 1;
    idle_inputs();

    //               icode rA    rB    valE        valM       valC      valP   cnd cc     chkA  chkB  pc       cc     ret  expA        expB
    vecs[0]  = '{4'h3, 4'hF, 4'h2, 64'd10,     64'h0,     64'h0,    64'hA,  0, 3'b000, 4'h2, 4'h4, 64'hA,  3'b001, 1,  64'd10,     64'h200};
    vecs[1]  = '{4'h6, 4'h2, 4'h5, 64'd10,     64'h0,     64'h0,    64'hC,  0, 3'b010, 4'h2, 4'h5, 64'hC,  3'b010, 2,  64'd10,     64'd10};
    vecs[2]  = '{4'h7, 4'hF, 4'hF, 64'h0,      64'h0,     64'h40,   64'h9,  0, 3'b111, 4'h2, 4'h5, 64'h9,  3'b010, 3,  64'd10,     64'd10};
    vecs[3]  = '{4'h8, 4'hF, 4'hF, 64'h1F8,    64'h0,     64'h40,   64'h12, 0, 3'b111, 4'h4, 4'h2, 64'h40, 3'b010, 4,  64'h1F8,    64'd10};
    vecs[4]  = '{4'h2, 4'h2, 4'h5, 64'h99,     64'h0,     64'h0,    64'h42, 0, 3'b000, 4'h5, 4'h2, 64'h42, 3'b010, 5,  64'd10,     64'd10};
    vecs[5]  = '{4'h2, 4'h2, 4'h6, 64'h77,     64'h0,     64'h0,    64'h44, 1, 3'b000, 4'h6, 4'h5, 64'h44, 3'b010, 6,  64'h77,     64'd10};
    vecs[6]  = '{4'h7, 4'hF, 4'hF, 64'h0,      64'h0,     64'h80,   64'h46, 1, 3'b000, 4'h6, 4'h4, 64'h80, 3'b010, 7,  64'h77,     64'h1F8};
    vecs[7]  = '{4'h9, 4'hF, 4'hF, 64'h200,    64'h50,    64'h0,    64'h81, 0, 3'b000, 4'h4, 4'h6, 64'h50, 3'b010, 8,  64'h200,    64'h77};
    vecs[8]  = '{4'hB, 4'h4, 4'hF, 64'h208,    64'h55,    64'h0,    64'h52, 0, 3'b000, 4'h4, 4'hF, 64'h52, 3'b010, 9,  64'h55,     64'h0};
    vecs[9]  = '{4'h5, 4'h7, 4'h3, 64'h1234,   64'hABC,   64'h0,    64'h5C, 0, 3'b111, 4'h7, 4'h3, 64'h5C, 3'b010, 10, 64'hABC,    64'h0};
    vecs[10] = '{4'h6, 4'h7, 4'hF, 64'h5,      64'h0,     64'h0,    64'h5E, 0, 3'b101, 4'hF, 4'h7, 64'h5E, 3'b101, 11, 64'h0,      64'hABC};
    vecs[11] = '{4'hA, 4'h7, 4'hF, 64'h4D,     64'h0,     64'h0,    64'h60, 0, 3'b000, 4'h4, 4'h6, 64'h60, 3'b101, 12, 64'h4D,     64'h77};

    // Reset state
    do_reset();
    srcA = 4'h4; srcB = 4'h2;
    #1;
    check("reset_pc", pc, 64'h0);
    check("reset_cc", 64'(cc_in), 64'(3'b001));
    check("reset_stat", 64'(stat), 64'd1);
    check("reset_retired", retired, 64'd0);
    check("reset_rsp", valA, 64'h200);
    check("reset_r2", valB, 64'h0);

    // Table-driven instruction stream
    for (int i = 0; i < 12; i++) begin
      do_commit(vecs[i].icode, vecs[i].rA, vecs[i].rB, vecs[i].valE, vecs[i].valM,
                vecs[i].valC, vecs[i].valP, vecs[i].cnd, vecs[i].cc_out, 1'b0);
      srcA = vecs[i].chk_a; srcB = vecs[i].chk_b;
      #1;
      check($sformatf("v%0d_pc", i), pc, vecs[i].exp_pc);
      check($sformatf("v%0d_cc", i), 64'(cc_in), 64'(vecs[i].exp_cc));
      check($sformatf("v%0d_stat", i), 64'(stat), 64'd1);
      check($sformatf("v%0d_ret", i), retired, vecs[i].exp_ret);
      check($sformatf("v%0d_valA", i), valA, vecs[i].exp_a);
      check($sformatf("v%0d_valB", i), valB, vecs[i].exp_b);
      srcA = 4'hF; srcB = 4'hF;
    end

    // Address fault: nothing written, state frozen afterwards
    do_commit(4'h3, 4'hF, 4'h2, 64'h999, 64'h0, 64'h0, 64'h99, 0, 3'b000, 1'b1);
    srcA = 4'h2; #1;
    check("adr_stat", 64'(stat), 64'd3);
    check("adr_pc", pc, 64'h60);
    check("adr_ret", retired, 64'd12);
    check("adr_r2", valA, 64'd10);
    do_commit(4'h3, 4'hF, 4'h2, 64'h888, 64'h0, 64'h0, 64'h77, 0, 3'b000, 1'b0);
    #1;
    check("adr_hold_stat", 64'(stat), 64'd3);
    check("adr_hold_pc", pc, 64'h60);
    check("adr_hold_ret", retired, 64'd12);
    check("adr_hold_r2", valA, 64'd10);
    do_reset();
    srcA = 4'h4; srcB = 4'h2; #1;
    check("rst2_stat", 64'(stat), 64'd1);
    check("rst2_pc", pc, 64'h0);
    check("rst2_ret", retired, 64'd0);
    check("rst2_rsp", valA, 64'h200);
    check("rst2_r2", valB, 64'h0);

    // Invalid instruction
    do_commit(4'hC, 4'hF, 4'h2, 64'h5, 64'h0, 64'h0, 64'h10, 0, 3'b110, 1'b0);
    #1;
    check("ins_stat", 64'(stat), 64'd4);
    check("ins_pc", pc, 64'h0);
    check("ins_ret", retired, 64'd0);
    check("ins_cc", 64'(cc_in), 64'(3'b001));
    check("ins_r2", valB, 64'h0);

    // Halt: PC holds, retired counts the halt, later commits ignored
    do_reset();
    do_commit(4'h3, 4'hF, 4'h2, 64'd21, 64'h0, 64'h0, 64'h30, 0, 3'b000, 1'b0);
    do_commit(4'h0, 4'hF, 4'hF, 64'h0, 64'h0, 64'h0, 64'h31, 0, 3'b000, 1'b0);
    srcA = 4'h2; #1;
    check("hlt_stat", 64'(stat), 64'd2);
    check("hlt_pc", pc, 64'h30);
    check("hlt_ret", retired, 64'd2);
    do_commit(4'h3, 4'hF, 4'h2, 64'd99, 64'h0, 64'h0, 64'h40, 0, 3'b000, 1'b0);
    #1;
    check("hlt_hold_stat", 64'(stat), 64'd2);
    check("hlt_hold_pc", pc, 64'h30);
    check("hlt_hold_ret", retired, 64'd2);
    check("hlt_hold_r2", valA, 64'd21);

    // Commit concurrent with reset is discarded
    @(negedge clk);
    reset_n = 0; commit = 1; icode = 4'h3; rA = 4'hF; rB = 4'h2; valE = 64'h42; valP = 64'h8;
    @(posedge clk);
    #1 reset_n = 1; commit = 0;
    srcA = 4'h2; #1;
    check("rstcommit_r2", valA, 64'h0);
    check("rstcommit_ret", retired, 64'd0);
    check("rstcommit_pc", pc, 64'h0);
    check("rstcommit_stat", 64'(stat), 64'd1);

    // Same-cycle read of the register being written
    @(negedge clk);
    commit = 1; icode = 4'h3; rA = 4'hF; rB = 4'h3; valE = 64'd7; valP = 64'h2;
    cnd = 0; mem_error = 0; srcA = 4'h3;
    #1;
`ifdef WB_FORWARD_EN
    check("fwd_same_cycle", valA, 64'd7);
`else
    check("nofwd_same_cycle", valA, 64'd0);
`endif
    @(posedge clk);
    #1 commit = 0;
    #1;
    check("fwd_next_cycle", valA, 64'd7);
    check("fwd_ret", retired, 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
